// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, address and branch/jump resolution, bit-serial shifter.
// EX/MEM and the shifter state update on the falling edge, in step with ID/EX.
`timescale 1ns/1ps

module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] pc,
    input  logic [2:0]  inst_type,
    input  logic [2:0]  funct3,
    input  logic [5:0]  funct7,
    input  logic [31:0] imm,
    input  logic [31:0] val_rs,
    input  logic [31:0] val_rs2,
    input  logic [4:0]  rd,
    output logic        stall,
    output logic [31:0] result_reg,
    output logic [31:0] store_data_reg,
    output logic [4:0]  rd_reg,
    output logic [2:0]  funct3_reg,
    output logic        mem_read_reg,
    output logic        mem_write_reg,
    output logic        reg_write_reg,
    output logic        valid_reg,
    output logic        redirect_reg,
    output logic [31:0] target_reg
);

    // state   | meaning
    // S_IDLE  | one instruction per edge; starts a serial shift when shamt >= 2
    // S_SHIFT | acc shifts once per edge; cnt==1 is the final, EX/MEM-writing edge
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    localparam logic [2:0] T_RALU   = 3'd0;
    localparam logic [2:0] T_IALU   = 3'd1;
    localparam logic [2:0] T_LOAD   = 3'd2;
    localparam logic [2:0] T_STORE  = 3'd3;
    localparam logic [2:0] T_BRANCH = 3'd4;
    localparam logic [2:0] T_JAL    = 3'd5;
    localparam logic [2:0] T_JALR   = 3'd6;
    localparam logic [2:0] T_AUIPC  = 3'd7;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] acc;
    logic        sh_left;
    logic        sh_arith;

    logic        v;
    logic        is_r;
    logic        is_alu;
    logic        is_shift;
    logic        shift_left;
    logic        shift_arith;
    logic        sub_sel;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [31:0] addr;
    logic [31:0] pc_imm;
    logic [31:0] link;
    logic        br_cond;
    logic        taken;
    logic [31:0] target;
    logic [31:0] result;
    logic        wr_en;
    logic        serial_start;
    logic        unused_funct7;

    assign unused_funct7 = ^funct7[4:0];

    function automatic logic [31:0] shift_once(input logic [31:0] x,
                                               input logic        left,
                                               input logic        arith);
        if (left)
            return {x[30:0], 1'b0};
        return {arith & x[31], x[31:1]};
    endfunction

    // A shift sitting behind a taken transfer is squashed and never reaches S_SHIFT.
    assign v           = in_valid & ~redirect_reg;
    assign is_r        = (inst_type == T_RALU);
    assign is_alu      = is_r | (inst_type == T_IALU);
    assign op_b        = is_r ? val_rs2 : imm;
    assign shamt       = op_b[4:0];
    assign shift_left  = (funct3 == 3'b001);
    assign shift_arith = funct7[5];
    assign sub_sel     = is_r & funct7[5];
    assign is_shift    = is_alu & ((funct3 == 3'b001) | (funct3 == 3'b101));
    assign addr        = val_rs + imm;
    assign pc_imm      = pc + imm;
    assign link        = pc + 32'd4;

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000:         alu_res = sub_sel ? (val_rs - op_b) : (val_rs + op_b);
            3'b001, 3'b101: alu_res = shamt[0] ? shift_once(val_rs, shift_left, shift_arith)
                                               : val_rs;
            3'b010:         alu_res = {31'b0, $signed(val_rs) < $signed(op_b)};
            3'b011:         alu_res = {31'b0, val_rs < op_b};
            3'b100:         alu_res = val_rs ^ op_b;
            3'b110:         alu_res = val_rs | op_b;
            3'b111:         alu_res = val_rs & op_b;
            default:        alu_res = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (val_rs == val_rs2);
            3'b001:  br_cond = (val_rs != val_rs2);
            3'b100:  br_cond = ($signed(val_rs) <  $signed(val_rs2));
            3'b101:  br_cond = ($signed(val_rs) >= $signed(val_rs2));
            3'b110:  br_cond = (val_rs <  val_rs2);
            3'b111:  br_cond = (val_rs >= val_rs2);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        result = pc_imm;
        case (inst_type)
            T_RALU, T_IALU:  result = alu_res;
            T_LOAD, T_STORE: result = addr;
            T_JAL, T_JALR:   result = link;
            T_AUIPC:         result = pc_imm;
            default:         result = pc_imm;
        endcase
    end

    assign taken  = v & (((inst_type == T_BRANCH) & br_cond) |
                         (inst_type == T_JAL) | (inst_type == T_JALR));
    assign target = (inst_type == T_JALR) ? {addr[31:1], 1'b0} : pc_imm;
    assign wr_en  = (inst_type != T_BRANCH) & (inst_type != T_STORE) & (rd != 5'd0);

    assign serial_start = v & is_shift & (shamt >= 5'd2);
    assign stall = ((state == S_IDLE) & serial_start) |
                   ((state == S_SHIFT) & (cnt != 5'd1));

    always_ff @(negedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            acc            <= '0;
            sh_left        <= 1'b0;
            sh_arith       <= 1'b0;
            result_reg     <= '0;
            store_data_reg <= '0;
            rd_reg         <= '0;
            funct3_reg     <= '0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            reg_write_reg  <= 1'b0;
            valid_reg      <= 1'b0;
            redirect_reg   <= 1'b0;
            target_reg     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    redirect_reg   <= taken;
                    target_reg     <= taken ? target : '0;
                    result_reg     <= result;
                    store_data_reg <= val_rs2;
                    rd_reg         <= rd;
                    funct3_reg     <= funct3;
                    if (serial_start) begin
                        acc           <= shift_once(val_rs, shift_left, shift_arith);
                        cnt           <= shamt - 5'd1;
                        sh_left       <= shift_left;
                        sh_arith      <= shift_arith;
                        state         <= S_SHIFT;
                        valid_reg     <= 1'b0;
                        reg_write_reg <= 1'b0;
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                    end else begin
                        valid_reg     <= v;
                        reg_write_reg <= v & wr_en;
                        mem_read_reg  <= v & (inst_type == T_LOAD);
                        mem_write_reg <= v & (inst_type == T_STORE);
                    end
                end
                S_SHIFT: begin
                    redirect_reg  <= 1'b0;
                    target_reg    <= '0;
                    acc           <= shift_once(acc, sh_left, sh_arith);
                    cnt           <= cnt - 5'd1;
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b0;
                    // ID/EX is held for the whole shift, so its fields are still valid here.
                    if (cnt == 5'd1) begin
                        result_reg     <= shift_once(acc, sh_left, sh_arith);
                        store_data_reg <= val_rs2;
                        rd_reg         <= rd;
                        funct3_reg     <= funct3;
                        valid_reg      <= 1'b1;
                        reg_write_reg  <= wr_en;
                        state          <= S_IDLE;
                    end else begin
                        valid_reg      <= 1'b0;
                        reg_write_reg  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed scenarios plus randomized instructions
// checked against an arithmetic reference model.
`timescale 1ns/1ps

module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] pc;
    logic [2:0]  inst_type;
    logic [2:0]  funct3;
    logic [5:0]  funct7;
    logic [31:0] imm;
    logic [31:0] val_rs;
    logic [31:0] val_rs2;
    logic [4:0]  rd;
    logic        stall;
    logic [31:0] result_reg;
    logic [31:0] store_data_reg;
    logic [4:0]  rd_reg;
    logic [2:0]  funct3_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic        reg_write_reg;
    logic        valid_reg;
    logic        redirect_reg;
    logic [31:0] target_reg;

    int checks = 0;
    int errors = 0;
    bit prev_taken = 1'b0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pc(pc), .inst_type(inst_type),
        .funct3(funct3), .funct7(funct7), .imm(imm), .val_rs(val_rs), .val_rs2(val_rs2),
        .rd(rd), .stall(stall), .result_reg(result_reg), .store_data_reg(store_data_reg),
        .rd_reg(rd_reg), .funct3_reg(funct3_reg), .mem_read_reg(mem_read_reg),
        .mem_write_reg(mem_write_reg), .reg_write_reg(reg_write_reg), .valid_reg(valid_reg),
        .redirect_reg(redirect_reg), .target_reg(target_reg)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: what the instruction computes, independent of how many edges it takes.
    function automatic void model(input logic [2:0] t, input logic [2:0] f3, input logic [5:0] f7,
                                  input logic [31:0] p, input logic [31:0] im,
                                  input logic [31:0] a, input logic [31:0] b2, input logic [4:0] r,
                                  output logic [31:0] res, output logic [31:0] tgt,
                                  output logic tk, output logic wr, output logic mr, output logic mw);
        logic [31:0] b;
        b   = (t == 3'd0) ? b2 : im;
        res = 32'd0;
        tgt = 32'd0;
        tk  = 1'b0;
        case (t)
            3'd0, 3'd1: begin
                case (f3)
                    3'd0: res = (t == 3'd0 && f7[5]) ? a - b : a + b;
                    3'd1: res = a << b[4:0];
                    3'd2: res = {31'd0, $signed(a) < $signed(b)};
                    3'd3: res = {31'd0, a < b};
                    3'd4: res = a ^ b;
                    3'd5: res = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                    3'd6: res = a | b;
                    default: res = a & b;
                endcase
            end
            3'd2, 3'd3: res = a + im;
            3'd4: begin
                case (f3)
                    3'd0: tk = (a == b2);
                    3'd1: tk = (a != b2);
                    3'd4: tk = ($signed(a) < $signed(b2));
                    3'd5: tk = ($signed(a) >= $signed(b2));
                    3'd6: tk = (a < b2);
                    3'd7: tk = (a >= b2);
                    default: tk = 1'b0;
                endcase
                tgt = p + im;
            end
            3'd5: begin tk = 1'b1; tgt = p + im; res = p + 32'd4; end
            3'd6: begin tk = 1'b1; tgt = (a + im) & ~32'd1; res = p + 32'd4; end
            default: res = p + im;
        endcase
        wr = (t != 3'd3) && (t != 3'd4) && (r != 5'd0);
        mr = (t == 3'd2);
        mw = (t == 3'd3);
    endfunction

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
        checks++;
        if (valid_reg !== 1'b0) begin
            errors++;
            $display("FAIL bubble_valid: got %b expected 0", valid_reg);
        end
        prev_taken = 1'b0;
    endtask

    // Issues one instruction and follows it through every edge it occupies the stage.
    task automatic exec(input logic [2:0] t, input logic [2:0] f3, input logic [5:0] f7,
                        input logic [31:0] p, input logic [31:0] im,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        logic [31:0] e_res, e_tgt;
        logic        e_tk, e_wr, e_mr, e_mw, e_stall;
        logic [4:0]  sh;
        int          lat;
        bit          sq;
        model(t, f3, f7, p, im, a, b, r, e_res, e_tgt, e_tk, e_wr, e_mr, e_mw);
        sq  = prev_taken;
        sh  = (t == 3'd0) ? b[4:0] : im[4:0];
        lat = 1;
        if (!sq && (t == 3'd0 || t == 3'd1) && (f3 == 3'd1 || f3 == 3'd5) && sh >= 5'd2)
            lat = int'(sh);
        inst_type = t; funct3 = f3; funct7 = f7; pc = p; imm = im;
        val_rs = a; val_rs2 = b; rd = r; in_valid = 1'b1;
        #1;
        for (int k = 1; k <= lat; k++) begin
            e_stall = (k < lat);
            checks++;
            if (stall !== e_stall) begin
                errors++;
                $display("FAIL stall(edge %0d of %0d): got %b expected %b", k, lat, stall, e_stall);
            end
            tick();
            if (k < lat) begin
                checks++;
                if (valid_reg !== 1'b0 || redirect_reg !== 1'b0) begin
                    errors++;
                    $display("FAIL shift_busy(edge %0d): got valid=%b redirect=%b expected 0 0",
                             k, valid_reg, redirect_reg);
                end
            end
        end
        if (sq) begin
            checks++;
            if ({valid_reg, reg_write_reg, mem_read_reg, mem_write_reg, redirect_reg} !== 5'b0) begin
                errors++;
                $display("FAIL squash: got v/rw/mr/mw/redir=%b expected 00000",
                         {valid_reg, reg_write_reg, mem_read_reg, mem_write_reg, redirect_reg});
            end
        end else begin
            checks++;
            if (valid_reg !== 1'b1) begin
                errors++;
                $display("FAIL valid_reg(type %0d): got %b expected 1", t, valid_reg);
            end
            checks++;
            if ({reg_write_reg, mem_read_reg, mem_write_reg} !== {e_wr, e_mr, e_mw}) begin
                errors++;
                $display("FAIL ctrl(type %0d): got rw/mr/mw=%b expected %b", t,
                         {reg_write_reg, mem_read_reg, mem_write_reg}, {e_wr, e_mr, e_mw});
            end
            checks++;
            if (redirect_reg !== e_tk) begin
                errors++;
                $display("FAIL redirect(type %0d f3 %0d): got %b expected %b", t, f3, redirect_reg, e_tk);
            end
            if (e_tk) begin
                checks++;
                if (target_reg !== e_tgt) begin
                    errors++;
                    $display("FAIL target: got %h expected %h", target_reg, e_tgt);
                end
            end
            if (t != 3'd4) begin
                checks++;
                if (result_reg !== e_res) begin
                    errors++;
                    $display("FAIL result(type %0d f3 %0d f7 %h a %h b %h imm %h): got %h expected %h",
                             t, f3, f7, a, b, im, result_reg, e_res);
                end
            end
            checks++;
            if (rd_reg !== r || funct3_reg !== f3) begin
                errors++;
                $display("FAIL rd/funct3: got %0d/%0d expected %0d/%0d", rd_reg, funct3_reg, r, f3);
            end
            if (t == 3'd3) begin
                checks++;
                if (store_data_reg !== b) begin
                    errors++;
                    $display("FAIL store_data: got %h expected %h", store_data_reg, b);
                end
            end
        end
        prev_taken = sq ? 1'b0 : e_tk;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_type = 3'd0; funct3 = 3'd0; funct7 = 6'd0; pc = 32'h10; imm = 32'd0;
        val_rs = 32'd5; val_rs2 = 32'd7; rd = 5'd1; in_valid = 1'b1;
        tick();
        tick();
        checks++;
        if ({result_reg, store_data_reg, rd_reg, funct3_reg, mem_read_reg, mem_write_reg,
             reg_write_reg, valid_reg, redirect_reg, target_reg} !== 109'd0) begin
            errors++;
            $display("FAIL reset_outputs: got result=%h valid=%b rw=%b expected all zero",
                     result_reg, valid_reg, reg_write_reg);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b expected 0", stall);
        end
        rst = 1'b0;
        prev_taken = 1'b0;
        exec(3'd0, 3'd0, 6'd0, 32'h10, 32'd0, 32'd5, 32'd7, 5'd1);
        checks++;
        if (result_reg !== 32'd12 || valid_reg !== 1'b1 || reg_write_reg !== 1'b1) begin
            errors++;
            $display("FAIL add_after_reset: got %h/%b/%b expected 0000000c/1/1",
                     result_reg, valid_reg, reg_write_reg);
        end
    endtask

    task automatic test_alu();
        exec(3'd0, 3'd0, 6'b100000, 32'h20, 32'd0, 32'h0, 32'h1, 5'd2);
        checks++;
        if (result_reg !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sub_wrap: got %h expected ffffffff", result_reg);
        end
        exec(3'd0, 3'd2, 6'd0, 32'h24, 32'd0, 32'hFFFF_FFFF, 32'h1, 5'd3);
        checks++;
        if (result_reg !== 32'd1) begin
            errors++;
            $display("FAIL slt: got %h expected 00000001", result_reg);
        end
        exec(3'd0, 3'd3, 6'd0, 32'h28, 32'd0, 32'hFFFF_FFFF, 32'h1, 5'd4);
        checks++;
        if (result_reg !== 32'd0) begin
            errors++;
            $display("FAIL sltu: got %h expected 00000000", result_reg);
        end
        exec(3'd1, 3'd1, 6'd0, 32'h2c, 32'd1, 32'h8000_0001, 32'h0, 5'd5);
        exec(3'd1, 3'd5, 6'd0, 32'h30, 32'd0, 32'h8000_0001, 32'h0, 5'd5);
    endtask

    task automatic test_serial_shift();
        exec(3'd0, 3'd5, 6'b100000, 32'h50, 32'd0, 32'h8000_0000, 32'd4, 5'd7);
        checks++;
        if (result_reg !== 32'hF800_0000) begin
            errors++;
            $display("FAIL sra4: got %h expected f8000000", result_reg);
        end
        exec(3'd0, 3'd0, 6'd0, 32'h54, 32'd0, 32'd3, 32'd4, 5'd8);
        exec(3'd1, 3'd1, 6'd0, 32'h58, 32'd31, 32'h1, 32'd0, 5'd9);
        exec(3'd0, 3'd5, 6'd0, 32'h5c, 32'd0, 32'h8000_0000, 32'd2, 5'd9);
    endtask

    task automatic test_branch();
        exec(3'd4, 3'd0, 6'd0, 32'h100, 32'h20, 32'd9, 32'd9, 5'd0);
        checks++;
        if (redirect_reg !== 1'b1 || target_reg !== 32'h120) begin
            errors++;
            $display("FAIL beq_taken: got %b/%h expected 1/00000120", redirect_reg, target_reg);
        end
        exec(3'd0, 3'd0, 6'd0, 32'h104, 32'd0, 32'd1, 32'd1, 5'd1);
        checks++;
        if (valid_reg !== 1'b0) begin
            errors++;
            $display("FAIL squashed_add: got valid %b expected 0", valid_reg);
        end
        exec(3'd4, 3'd0, 6'd0, 32'h120, 32'h20, 32'd9, 32'd8, 5'd0);
        exec(3'd0, 3'd0, 6'd0, 32'h124, 32'd0, 32'd1, 32'd1, 5'd1);
        checks++;
        if (valid_reg !== 1'b1 || result_reg !== 32'd2) begin
            errors++;
            $display("FAIL after_not_taken: got %b/%h expected 1/00000002", valid_reg, result_reg);
        end
        exec(3'd5, 3'd0, 6'd0, 32'h200, 32'hFFFF_FFF0, 32'd0, 32'd0, 5'd1);
        exec(3'd0, 3'd1, 6'd0, 32'h204, 32'd0, 32'd1, 32'd9, 5'd1);
    endtask

    task automatic test_jalr();
        exec(3'd6, 3'd0, 6'd0, 32'h40, 32'd2, 32'h1001, 32'd0, 5'd1);
        checks++;
        if (target_reg !== 32'h1002 || result_reg !== 32'h44) begin
            errors++;
            $display("FAIL jalr: got target %h result %h expected 00001002 00000044",
                     target_reg, result_reg);
        end
        idle();
        exec(3'd6, 3'd0, 6'd0, 32'h40, 32'd2, 32'h1001, 32'd0, 5'd0);
        checks++;
        if (reg_write_reg !== 1'b0) begin
            errors++;
            $display("FAIL jalr_rd0: got reg_write %b expected 0", reg_write_reg);
        end
        idle();
    endtask

    task automatic test_reset_mid_shift();
        inst_type = 3'd0; funct3 = 3'd1; funct7 = 6'd0; pc = 32'h300; imm = 32'd0;
        val_rs = 32'h1; val_rs2 = 32'd20; rd = 5'd3; in_valid = 1'b1;
        #1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (stall !== 1'b1) begin
                errors++;
                $display("FAIL sll20_stall(edge %0d): got %b expected 1", k, stall);
            end
            tick();
        end
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || valid_reg !== 1'b0 || result_reg !== 32'd0) begin
            errors++;
            $display("FAIL mid_shift_reset: got stall %b valid %b result %h expected 0 0 00000000",
                     stall, valid_reg, result_reg);
        end
        prev_taken = 1'b0;
        idle();
        exec(3'd3, 3'd2, 6'd0, 32'h304, 32'hFFFF_FFFC, 32'h200, 32'hDEAD_BEEF, 5'd0);
        checks++;
        if (result_reg !== 32'h1FC || mem_write_reg !== 1'b1) begin
            errors++;
            $display("FAIL sw_after_reset: got %h/%b expected 000001fc/1", result_reg, mem_write_reg);
        end
    endtask

    task automatic test_random();
        logic [2:0]  t, f3;
        logic [5:0]  f7;
        logic [31:0] a, b, im, p;
        for (int n = 0; n < 300; n++) begin
            t  = 3'($urandom_range(0, 7));
            f3 = 3'($urandom_range(0, 7));
            f7 = ($urandom_range(0, 1) == 1) ? 6'b100000 : 6'd0;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            im = $urandom;
            p  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            exec(t, f3, f7, p, im, a, b, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 7) == 0)
                idle();
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        pc = 32'd0; inst_type = 3'd0; funct3 = 3'd0; funct7 = 6'd0;
        imm = 32'd0; val_rs = 32'd0; val_rs2 = 32'd0; rd = 5'd0;
        test_reset();
        test_alu();
        test_serial_shift();
        test_branch();
        test_jalr();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the RV32I pipeline. It consumes the ID/EX register outputs, performs ALU, address and branch/jump computation, and writes the EX/MEM register. Shifts run on a bit-serial shifter, one bit per cycle, and the stage stalls the upstream stages while a shift is in progress. Taken branches and jumps are reported to fetch as a registered redirect.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on the falling edge, matching the ID/EX register.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  the ID/EX register holds a real instruction.
- pc  in  32  instruction PC.
- inst_type  in  3  0 R-ALU, 1 I-ALU, 2 load, 3 store, 4 branch, 5 JAL, 6 JALR, 7 AUIPC. LUI arrives as I-ALU ADD with val_rs=0.
- funct3  in  3  RV32I funct3.
- funct7  in  6  bit 5 selects SUB (R-type only) and SRA/SRAI.
- imm  in  32  sign-extended immediate.
- val_rs, val_rs2  in  32  operands.
- rd  in  5  destination register.
- stall  out  1  hold IF/ID and ID/EX; combinational.
- result_reg  out  32  ALU result, effective address, or link address (pc+4).
- store_data_reg  out  32  val_rs2 for stores.
- rd_reg  out  5  destination register.
- funct3_reg  out  3  access width for the memory stage.
- mem_read_reg, mem_write_reg, reg_write_reg  out  1  control bits for the memory and write-back stages.
- valid_reg  out  1  EX/MEM entry is valid.
- redirect_reg  out  1  taken branch or jump; high for one cycle.
- target_reg  out  32  redirect target.

## Operation
- The effective input valid is `v = in_valid & ~redirect_reg`. The instruction immediately behind a taken control transfer is squashed here; upstream flushes IF/ID using redirect_reg.
- ALU operand B is val_rs2 for R-type and imm otherwise.
- ALU operations: ADD/SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, all 32-bit wrap-around. SLT is signed and SLTU unsigned.
- Load and store address: val_rs + imm, with carry discarded.
- AUIPC result: pc + imm.
- Branch: the funct3 compare (BEQ, BNE, BLT, BGE, BLTU, BGEU) on val_rs and val_rs2 selects target pc + imm. A not-taken branch leaves redirect_reg low.
- JAL: target pc + imm, result pc + 4.
- JALR: target (val_rs + imm) with bit 0 cleared, result pc + 4.
- reg_write is set for ALU, load, JAL, JALR and AUIPC when rd≠0. Branches and stores never write.
- Shift amount is operand B[4:0]. A shift with shamt 0 or 1 completes in one cycle like any ALU op.
- Shifter FSM:
  - IDLE: on v & shift & shamt≥2, load acc with the operand shifted once, set cnt=shamt−1, go to SHIFT, and write valid_reg=0.
  - SHIFT: on each edge, shift acc once and decrement cnt.
  - SHIFT, cnt==1: this edge writes the final result and all control bits into EX/MEM with valid_reg=1, then returns to IDLE.
  - SRA replicates bit 31 on every step.
- stall = (IDLE & v & shift & shamt≥2) | (SHIFT & cnt≠1). ID/EX is held and stable throughout the shift. The instruction is released on the final edge.
- When v=0 in IDLE, EX/MEM is written as a bubble: valid_reg, reg_write_reg, mem_read_reg and mem_write_reg are 0. The data fields are don't-care.
- Reset values: every output register 0, state IDLE, cnt 0, so stall=0.
- Reset mid-shift: the FSM returns to IDLE, the partial result is discarded, and no EX/MEM write occurs.

## Timing
- Latency is one falling edge from ID/EX to EX/MEM for all non-serial ops.
- Serial shifts take shamt edges, with shamt≥2. Throughput is one instruction per cycle otherwise.
- redirect_reg and target_reg are written on the same edge as the branch's EX/MEM entry. They clear on the next edge unless another taken transfer arrives, which cannot happen because that input is squashed.
- redirect_reg and a shift cannot coexist: a squashed shift never enters SHIFT.

## Test plan
- Reset with in_valid=1 -> all outputs 0, stall 0. After release, ADD 5+7 gives result_reg=12, valid_reg=1, reg_write_reg=1 one edge later.
- SUB 0x00000000−1 -> 0xFFFFFFFF. SLT(−1,1)=1; SLTU(0xFFFFFFFF,1)=0.
- SRA 0x80000000 by 4 -> stall high for 3 cycles, then result 0xF8000000 on the 4th edge. valid_reg=0 on edges 1–3. The next instruction executes on edge 5.
- BEQ at pc=0x100, imm=0x20, equal operands -> redirect_reg=1, target 0x120 for one cycle; the following ADD is squashed (valid_reg=0). With unequal operands: no redirect, and the following op executes.
- JALR at pc=0x40, val_rs=0x1001, imm=2 -> target 0x1002, result 0x44. With rd=0, reg_write_reg=0.
- Assert rst during a 20-bit SLL at edge 5 -> FSM in IDLE, stall 0, no EX/MEM write. The subsequent SW with val_rs=0x200, imm=−4 gives result 0x1FC and mem_write_reg=1.
